cond_logic: RTL and testbench

//   Consumer end of the ALU flag interface: holds the architectural NZCV flags.
//   - Registers ALU flags under per-group write enables.
//   - Evaluates the 4-bit ARM condition field against the stored flags.
//   - Gates the controller's PC/register/memory/flag write strobes for the multicycle datapath.
//   - The condition verdict is captured once per instruction, then applied to all later write strobes.

---
 rtl/cond_logic.sv | 96 +++++++++
 tb/tb_cond_logic.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_logic.sv
// cond_logic: consumer end of the ALU flag interface for a multicycle ARM datapath.
//   Holds the architectural {N,Z,C,V} flags, evaluates the instruction condition field
//   against them, and gates the controller's PC/register/memory/flag write strobes with a
//   per-instruction condition verdict captured while CondLatch is high.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   Cond[3:0]            instruction condition field
//   ALUFlags[3:0]        {N,Z,C,V} from the ALU
//   FlagW[1:0]           ungated flag-group write requests ([1]: N,Z  [0]: C,V)
//   CondLatch            capture the condition verdict
//   PCS, NextPC          conditional PC write / unconditional PC increment
//   RegW, MemW, NoWrite  register write, memory write, compare-op register-write suppress
//   Flags[3:0]           stored {N,Z,C,V}
//   CondEx               combinational verdict of Cond against the stored flags
//   PCWrite, RegWrite, MemWrite  gated write enables
module cond_logic #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         NV_IS_NEVER = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       CondLatch,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic [3:0] Flags,
  output logic       CondEx,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite
);

  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;
  logic [1:0] flag_write;

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    logic r;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = cf;
      4'b0011: r = ~cf;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = cf & ~z;
      4'b1001: r = ~cf | z;
      4'b1010: r = ~(n ^ v);
      4'b1011: r = n ^ v;
      4'b1100: r = ~z & ~(n ^ v);
      4'b1101: r = z | (n ^ v);
      4'b1110: r = 1'b1;
      default: r = ~NV_IS_NEVER;
    endcase
    return r;
  endfunction

  // Stage 0: condition evaluation and write gating (combinational on stored state)
  assign CondEx     = cond_eval(Cond, flags_q);
  assign flag_write = FlagW & {2{condex_q}};
  assign PCWrite    = NextPC | (PCS & condex_q);
  assign RegWrite   = RegW & ~NoWrite & condex_q;
  assign MemWrite   = MemW & condex_q;
  assign Flags      = flags_q;

  // Latch samples the old flags and the flag write uses the old verdict, so a
  // simultaneous CondLatch and flag write both see pre-edge state.
  always_comb begin
    flags_d  = flags_q;
    condex_d = condex_q;
    if (flag_write[1]) flags_d[3:2] = ALUFlags[3:2];
    if (flag_write[0]) flags_d[1:0] = ALUFlags[1:0];
    if (CondLatch)     condex_d     = CondEx;
  end

  // Stage 1: architectural state; reset drops any pending gated flag write
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q  <= RESET_FLAGS;
      condex_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       CondLatch, PCS, NextPC, RegW, MemW, NoWrite;

  logic [3:0] Flags_a, Flags_b;
  logic       CondEx_a, PCWrite_a, RegWrite_a, MemWrite_a;
  logic       CondEx_b, PCWrite_b, RegWrite_b, MemWrite_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state per instance: 0 = default params, 1 = NV evaluates true, reset flags 1010
  logic [3:0] m_flags [2];
  logic       m_cex   [2];

  always #5 clk = ~clk;

  cond_logic #(.RESET_FLAGS(4'b0000), .NV_IS_NEVER(1'b1)) dut_a (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .CondLatch(CondLatch), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .NoWrite(NoWrite), .Flags(Flags_a), .CondEx(CondEx_a), .PCWrite(PCWrite_a),
    .RegWrite(RegWrite_a), .MemWrite(MemWrite_a));

  cond_logic #(.RESET_FLAGS(4'b1010), .NV_IS_NEVER(1'b0)) dut_b (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .CondLatch(CondLatch), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .NoWrite(NoWrite), .Flags(Flags_b), .CondEx(CondEx_b), .PCWrite(PCWrite_b),
    .RegWrite(RegWrite_b), .MemWrite(MemWrite_b));

  // Golden condition table: odd codes invert the predicate of the even code below them.
  function automatic logic golden(input logic [3:0] c, input logic [3:0] f, input bit nv_never);
    bit n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return !nv_never;
    return base ^ c[0];
  endfunction

  function automatic bit nvn(input int k);
    return (k == 0);
  endfunction

  function automatic logic [3:0] rst_val(input int k);
    return (k == 0) ? 4'b0000 : 4'b1010;
  endfunction

  function automatic logic [7:0] exp_vec(input int k);
    return {m_flags[k], golden(Cond, m_flags[k], nvn(k)),
            NextPC | (PCS & m_cex[k]), RegW & !NoWrite & m_cex[k], MemW & m_cex[k]};
  endfunction

  function automatic logic [7:0] act_vec(input int k);
    if (k == 0) return {Flags_a, CondEx_a, PCWrite_a, RegWrite_a, MemWrite_a};
    return {Flags_b, CondEx_b, PCWrite_b, RegWrite_b, MemWrite_b};
  endfunction

  // Advance one clock, updating the reference model from the inputs held across the edge.
  task automatic tick();
    logic [3:0] nf [2];
    logic       nc [2];
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        nf[k] = rst_val(k);
        nc[k] = 1'b0;
      end else begin
        nf[k] = m_flags[k];
        if (FlagW[1] && m_cex[k]) nf[k][3:2] = ALUFlags[3:2];
        if (FlagW[0] && m_cex[k]) nf[k][1:0] = ALUFlags[1:0];
        nc[k] = CondLatch ? golden(Cond, m_flags[k], nvn(k)) : m_cex[k];
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_flags[k] = nf[k];
      m_cex[k]   = nc[k];
    end
  endtask

  task automatic idle_inputs();
    Cond = 4'b0000; ALUFlags = 4'b0000; FlagW = 2'b00; CondLatch = 1'b0;
    PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
  endtask

  // Latch AL, then write both flag groups; leaves the verdict register at 1.
  task automatic load_flags(input logic [3:0] f);
    FlagW = 2'b00; Cond = 4'b1110; CondLatch = 1'b1;
    tick();
    CondLatch = 1'b0; FlagW = 2'b11; ALUFlags = f;
    tick();
    FlagW = 2'b00;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111; CondLatch = 1'b1; Cond = 4'b1110;
    tick();
    tick();
    reset = 1'b0; CondLatch = 1'b0; FlagW = 2'b11;
    RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; NextPC = 1'b0;
    #1;
    n_tests++;
    if ({Flags_a, RegWrite_a, MemWrite_a, PCWrite_a} !== 7'b0000_000) begin
      n_fail++;
      $display("FAIL reset_state: got flags=%b rw=%b mw=%b pcw=%b, want 0000 0 0 0",
               Flags_a, RegWrite_a, MemWrite_a, PCWrite_a);
    end
    n_tests++;
    if (Flags_b !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_flags_param: got %b want 1010", Flags_b);
    end
    tick();
    n_tests++;
    if (Flags_a !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_hold_nowrite: got flags=%b want 0000", Flags_a);
    end
    NextPC = 1'b1;
    #1;
    n_tests++;
    if (PCWrite_a !== 1'b1) begin
      n_fail++;
      $display("FAIL nextpc_after_reset: got pcw=%b want 1", PCWrite_a);
    end
    idle_inputs();
  endtask

  task automatic test_flag_update();
    Cond = 4'b1110; CondLatch = 1'b1;
    tick();
    CondLatch = 1'b0; FlagW = 2'b11; ALUFlags = 4'b0110;
    tick();
    FlagW = 2'b00; Cond = 4'b0000;
    #1;
    n_tests++;
    if ({Flags_a, CondEx_a} !== 5'b0110_1) begin
      n_fail++;
      $display("FAIL flag_write_both: got flags=%b condex=%b want 0110 1", Flags_a, CondEx_a);
    end
    FlagW = 2'b01; ALUFlags = 4'b1001;
    tick();
    FlagW = 2'b00;
    #1;
    n_tests++;
    if (Flags_a !== 4'b0101) begin
      n_fail++;
      $display("FAIL flag_write_cv_only: got %b want 0101", Flags_a);
    end
    load_flags(4'b0000);
    FlagW = 2'b10; ALUFlags = 4'b1111;
    tick();
    FlagW = 2'b00;
    #1;
    n_tests++;
    if (Flags_a !== 4'b1100) begin
      n_fail++;
      $display("FAIL flag_write_nz_only: got %b want 1100", Flags_a);
    end
  endtask

  task automatic test_signed_conds();
    logic [3:0] codes [4];
    logic       want  [4];
    codes[0] = 4'b1011; want[0] = 1'b1;
    codes[1] = 4'b1010; want[1] = 1'b0;
    codes[2] = 4'b1100; want[2] = 1'b0;
    codes[3] = 4'b1101; want[3] = 1'b1;
    load_flags(4'b1000);
    for (int i = 0; i < 4; i++) begin
      Cond = codes[i];
      #1;
      n_tests++;
      if (CondEx_a !== want[i]) begin
        n_fail++;
        $display("FAIL signed_cond_%b: got %b want %b", codes[i], CondEx_a, want[i]);
      end
    end
  endtask

  task automatic test_gated_off();
    load_flags(4'b0010);
    Cond = 4'b0000; CondLatch = 1'b1;
    tick();
    CondLatch = 1'b0; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1101;
    #1;
    n_tests++;
    if ({RegWrite_a, MemWrite_a, PCWrite_a} !== 3'b000) begin
      n_fail++;
      $display("FAIL gated_off_strobes: got rw=%b mw=%b pcw=%b want 000",
               RegWrite_a, MemWrite_a, PCWrite_a);
    end
    tick();
    n_tests++;
    if (Flags_a !== 4'b0010) begin
      n_fail++;
      $display("FAIL gated_off_flags: got %b want 0010", Flags_a);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    // Latch a false EQ while writing flags: the write uses the old (true) verdict.
    load_flags(4'b0000);
    Cond = 4'b0000; CondLatch = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0100;
    tick();
    CondLatch = 1'b0; FlagW = 2'b00; RegW = 1'b1;
    #1;
    n_tests++;
    if ({Flags_a, RegWrite_a} !== 5'b0100_0) begin
      n_fail++;
      $display("FAIL latch_and_write_same_edge: got flags=%b rw=%b want 0100 0", Flags_a, RegWrite_a);
    end
    // NextPC overrides a false verdict; NoWrite suppresses a true one.
    PCS = 1'b1; NextPC = 1'b1;
    #1;
    n_tests++;
    if (PCWrite_a !== 1'b1) begin
      n_fail++;
      $display("FAIL nextpc_and_pcs: got %b want 1", PCWrite_a);
    end
    load_flags(4'b0000);
    RegW = 1'b1; NoWrite = 1'b1;
    #1;
    n_tests++;
    if (RegWrite_a !== 1'b0) begin
      n_fail++;
      $display("FAIL nowrite_suppress: got %b want 0", RegWrite_a);
    end
    // Reset with a pending write: write dropped, flags take reset value.
    NoWrite = 1'b0; FlagW = 2'b11; ALUFlags = 4'b0101; reset = 1'b1;
    tick();
    reset = 1'b0; FlagW = 2'b00;
    #1;
    n_tests++;
    if ({Flags_a, Flags_b, RegWrite_a} !== 9'b0000_1010_0) begin
      n_fail++;
      $display("FAIL reset_mid_instr: got a=%b b=%b rw=%b want 0000 1010 0", Flags_a, Flags_b, RegWrite_a);
    end
    idle_inputs();
  endtask

  task automatic test_cond_sweep();
    int bad = 0;
    for (int f = 0; f < 16; f++) begin
      load_flags(f[3:0]);
      for (int c = 0; c < 16; c++) begin
        Cond = c[3:0];
        #1;
        n_tests++;
        if (CondEx_a !== golden(c[3:0], f[3:0], 1'b1) || CondEx_b !== golden(c[3:0], f[3:0], 1'b0)) begin
          n_fail++;
          $display("FAIL cond_sweep c=%b f=%b: got a=%b b=%b want a=%b b=%b", c[3:0], f[3:0],
                   CondEx_a, CondEx_b, golden(c[3:0], f[3:0], 1'b1), golden(c[3:0], f[3:0], 1'b0));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 39) == 0);
      Cond      = 4'($urandom);
      ALUFlags  = 4'($urandom);
      FlagW     = 2'($urandom);
      CondLatch = ($urandom_range(0, 2) == 0);
      PCS = 1'($urandom); NextPC = 1'($urandom); RegW = 1'($urandom);
      MemW = 1'($urandom); NoWrite = 1'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (act_vec(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL random_%0d inst%0d: got {flags,cex,pcw,rw,mw}=%b want %b",
                   i, k, act_vec(k), exp_vec(k));
        end
      end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      m_flags[k] = rst_val(k);
      m_cex[k]   = 1'b0;
    end
    test_reset();
    test_flag_update();
    test_signed_conds();
    test_gated_off();
    test_back_to_back();
    test_cond_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
